fir_tap_line: RTL and testbench
===============================

# fir_tap_line

Input stage of the FIR datapath. It accepts a stream of signed samples through a valid/ready handshake and shifts each one into a TAPS-deep delay line. It holds a double-buffered coefficient bank. After every accepted sample, once the line is full, it presents the complete tap window and the active coefficients to the downstream MAC stage with a one-cycle window-valid strobe.

## Interface
- DATA_WIDTH, 13: sample and coefficient width, signed two's complement.
- TAPS, 8: delay-line depth and coefficient count; must be ≥2.
- CLK  in  1  clock; all state updates on rising edge.
- RST_n  in  1  reset, asynchronous, active-low.
- DIN  in  DATA_WIDTH  signed input sample.
- DIN_VALID  in  1  DIN holds a sample.
- DIN_READY  out  1  block can accept; a sample is accepted on an edge where DIN_VALID && DIN_READY.
- COEF_WE  in  1  write COEF_DATA into shadow coefficient COEF_ADDR.
- COEF_ADDR  in  $clog2(TAPS)  shadow write index; values ≥TAPS are ignored.
- COEF_DATA  in  DATA_WIDTH  signed coefficient.
- COEF_COMMIT  in  1  copy the whole shadow bank into the active bank.
- FLUSH  in  1  flush request; acted on only with FIR_TAPLINE_FLUSH_EN.
- TP_W[0:TAPS-1]  out  DATA_WIDTH each  tap window; index 0 = newest sample.
- H[0:TAPS-1]  out  DATA_WIDTH each  active coefficients.
- WIN_VALID  out  1  one-cycle strobe: TP_W/H form a new complete window.

## Operation
- FSM states:
  - FILL: fill count below TAPS.
  - RUN: line full.
  - FLUSH: only with macro.
  - Reset state: FILL with count 0.
- Sample acceptance: TP_W[i] <= TP_W[i-1] for i≥1, and TP_W[0] <= DIN. The fill counter ($clog2(TAPS+1) bits) increments and saturates at TAPS.
- FILL → RUN on the acceptance that brings the count to TAPS. RUN has no other exit except FLUSH or reset.
- WIN_VALID is registered. It is 1 in the cycle after an acceptance whose post-update count equals TAPS, and 0 otherwise.
- No arithmetic is performed on samples; data is passed unmodified at full DATA_WIDTH.
- DIN_READY = (state != FLUSH). It is a pure state decode with no combinational path from any input.
- Coefficient bank:
  - COEF_WE writes the shadow bank only.
  - COEF_COMMIT updates all of H on the same edge.
  - COEF_WE and COEF_COMMIT in the same cycle: the newly written value is included in the commit.
  - A commit coinciding with a sample acceptance means the resulting window is presented with the new H.
- Reset mid-operation: all registers clear immediately. Any partially filled or in-flight window is discarded, and the line must refill with TAPS samples.

## Timing
- Reset values:
  - TP_W all 0; H all 0; shadow all 0.
  - WIN_VALID 0.
  - DIN_READY 1.
- Latency: sample accepted at edge k → visible on TP_W[0] and WIN_VALID (if full) after edge k. The MAC samples the window at edge k+1.
- Throughput: one sample per cycle; back-to-back acceptances give back-to-back WIN_VALID.
- Idle cycles (DIN_VALID low) produce WIN_VALID 0 and hold TP_W.

## Configuration
- FIR_TAPLINE_FLUSH_EN defined:
  - FLUSH sampled high in RUN → FLUSH state. FLUSH in FILL is ignored.
  - In FLUSH: DIN_READY 0, and zero is shifted in each cycle for TAPS-1 cycles, each with a WIN_VALID strobe.
  - Then TP_W clears to 0, the count goes to 0, and the state goes to FILL.
- Macro undefined: the FLUSH port exists but is ignored; the FLUSH state is not compiled; DIN_READY is constant 1 after reset.

## Structure
- Package fir_pkg holds:
  - DATA_WIDTH/TAPS defaults, shared with mac_u instantiation.
  - typedef sample_t (signed [DATA_WIDTH-1:0]).
  - The tap-line state enum.
- Sub-module fir_coef_bank contains the shadow and active arrays, write/commit logic and commit write-through. The top holds the FSM, counter and delay line.

## Test plan
- TAPS=8. Reset, then samples 1..8 back-to-back → WIN_VALID first high the cycle after the 8th acceptance with TP_W={8,7,6,5,4,3,2,1}; no earlier WIN_VALID.
- Then sample 9 after 3 idle cycles → WIN_VALID low during the idle cycles, a single pulse afterwards, TP_W={9,...,2}.
- Shadow writes H[i]=i+1 with no commit → H stays 0. COEF_COMMIT → H={1..8} next cycle. COEF_WE addr 3 = 100 together with COEF_COMMIT → H[3]=100.
- RST_n low mid-RUN → outputs zero immediately. The next 7 samples give no WIN_VALID; the 8th does.
- FIR_TAPLINE_FLUSH_EN, FLUSH in RUN with window {8..1} → DIN_READY low 7 cycles with 7 WIN_VALID pulses (TP_W[0]=0 each). Then TP_W all 0, DIN_READY 1, FILL.
- FIR_TAPLINE_FLUSH_EN, FLUSH in FILL with count 3 → ignored; the 5th further sample completes the fill.

Source files
------------

// File: rtl/fir_pkg.sv
// fir_pkg: shared definitions for the FIR datapath.
//   DEF_DATA_WIDTH / DEF_TAPS : default sample width and tap count, also
//                               used when instantiating the MAC stage.
//   sample_t                  : signed sample/coefficient type.
//   tapState_t                : tap-line FSM states. ST_FLUSH exists only
//                               when FIR_TAPLINE_FLUSH_EN is defined.
package fir_pkg;

  localparam int DEF_DATA_WIDTH = 13;
  localparam int DEF_TAPS       = 8;

  typedef logic signed [DEF_DATA_WIDTH-1:0] sample_t;

`ifdef FIR_TAPLINE_FLUSH_EN
  typedef enum logic [1:0] {
    ST_FILL  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FLUSH = 2'd2
  } tapState_t;
`else
  typedef enum logic [1:0] {
    ST_FILL  = 2'd0,
    ST_RUN   = 2'd1
  } tapState_t;
`endif

endpackage : fir_pkg

// File: rtl/fir_tap_line_coef_bank.sv
// fir_coef_bank: double-buffered coefficient storage for the FIR tap line.
//   CLK, RST_n      : clock, asynchronous active-low reset.
//   i_coefWe        : write i_coefData into shadow entry i_coefAddr.
//   i_coefAddr      : shadow write index; indices >= TAPS are dropped.
//   i_coefData      : signed coefficient value.
//   i_coefCommit    : copy the whole shadow bank into the active bank.
//   o_h[0:TAPS-1]   : active coefficients.
module fir_coef_bank
  import fir_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int TAPS       = DEF_TAPS
) (
  input  logic                         CLK,
  input  logic                         RST_n,
  input  logic                         i_coefWe,
  input  logic [$clog2(TAPS)-1:0]      i_coefAddr,
  input  logic signed [DATA_WIDTH-1:0] i_coefData,
  input  logic                         i_coefCommit,
  output logic signed [DATA_WIDTH-1:0] o_h [0:TAPS-1]
);

  logic signed [DATA_WIDTH-1:0] r_shadow [0:TAPS-1];
  logic signed [DATA_WIDTH-1:0] r_active [0:TAPS-1];

  // A write landing in the same cycle as a commit is forwarded straight
  // into the active bank so the commit always sees the newest value.
  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      for (int i = 0; i < TAPS; i++) begin
        r_shadow[i] <= '0;
        r_active[i] <= '0;
      end
    end else begin
      for (int i = 0; i < TAPS; i++) begin
        if (i_coefWe && (int'(i_coefAddr) == i)) begin
          r_shadow[i] <= i_coefData;
        end
        if (i_coefCommit) begin
          r_active[i] <= (i_coefWe && (int'(i_coefAddr) == i)) ? i_coefData : r_shadow[i];
        end
      end
    end
  end

  assign o_h = r_active;

endmodule : fir_coef_bank

// File: rtl/fir_tap_line.sv
// fir_tap_line: input stage of the FIR datapath. Shifts accepted samples
// into a TAPS-deep delay line and strobes WIN_VALID for one cycle after
// each acceptance once the line is full.
//   CLK, RST_n          : clock, asynchronous active-low reset.
//   DIN/DIN_VALID       : sample input; accepted when DIN_VALID && DIN_READY.
//   DIN_READY           : decode of the FSM state only.
//   COEF_WE/ADDR/DATA   : shadow coefficient write port.
//   COEF_COMMIT         : shadow -> active coefficient copy.
//   FLUSH               : flush request (used only with the macro below).
//   TP_W[0:TAPS-1]      : tap window, index 0 = newest sample.
//   H[0:TAPS-1]         : active coefficients.
//   WIN_VALID           : registered one-cycle window strobe.
// Optional feature: define FIR_TAPLINE_FLUSH_EN to enable the FLUSH state.
module fir_tap_line
  import fir_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int TAPS       = DEF_TAPS
) (
  input  logic                         CLK,
  input  logic                         RST_n,
  input  logic signed [DATA_WIDTH-1:0] DIN,
  input  logic                         DIN_VALID,
  output logic                         DIN_READY,
  input  logic                         COEF_WE,
  input  logic [$clog2(TAPS)-1:0]      COEF_ADDR,
  input  logic signed [DATA_WIDTH-1:0] COEF_DATA,
  input  logic                         COEF_COMMIT,
  input  logic                         FLUSH,
  output logic signed [DATA_WIDTH-1:0] TP_W [0:TAPS-1],
  output logic signed [DATA_WIDTH-1:0] H [0:TAPS-1],
  output logic                         WIN_VALID
);

  localparam int CW = $clog2(TAPS + 1);
  localparam logic [CW-1:0] FULL_COUNT = CW'(TAPS);

  tapState_t r_state;
  tapState_t w_nextState;

  logic [CW-1:0]                r_count;
  logic [CW-1:0]                w_countNext;
  logic signed [DATA_WIDTH-1:0] r_tapLine [0:TAPS-1];
  logic                         r_winValid;
  logic                         w_accept;
  logic                         w_shiftZero;
  logic                         w_clearLine;

`ifdef FIR_TAPLINE_FLUSH_EN
  localparam int FW = (TAPS > 2) ? $clog2(TAPS - 1) : 1;
  localparam logic [FW-1:0] FLUSH_LAST = FW'(TAPS - 2);
  logic [FW-1:0] r_flushCnt;
`else
  logic w_unusedFlush;
  assign w_unusedFlush = FLUSH;
`endif

  // Fill counter saturates at TAPS so RUN keeps strobing every acceptance.
  assign w_countNext = (r_count == FULL_COUNT) ? r_count : r_count + 1'b1;

  always_comb begin
    w_nextState = r_state;
    w_accept    = 1'b0;
    w_shiftZero = 1'b0;
    w_clearLine = 1'b0;
    case (r_state)
      ST_FILL: begin
        w_accept = DIN_VALID;
        if (DIN_VALID && (w_countNext == FULL_COUNT)) begin
          w_nextState = ST_RUN;
        end
      end
      ST_RUN: begin
        w_accept = DIN_VALID;
`ifdef FIR_TAPLINE_FLUSH_EN
        if (FLUSH) begin
          w_nextState = ST_FLUSH;
        end
`endif
      end
`ifdef FIR_TAPLINE_FLUSH_EN
      // TAPS-1 strobed cycles: the first TAPS-2 shift a zero in, the last
      // one clears the whole line (the only non-zero tap left would be
      // dropped by the clear anyway) and returns to FILL.
      ST_FLUSH: begin
        if (r_flushCnt == FLUSH_LAST) begin
          w_clearLine = 1'b1;
          w_nextState = ST_FILL;
        end else begin
          w_shiftZero = 1'b1;
        end
      end
`endif
      default: begin
        w_nextState = ST_FILL;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      r_state    <= ST_FILL;
      r_count    <= '0;
      r_winValid <= 1'b0;
      for (int i = 0; i < TAPS; i++) begin
        r_tapLine[i] <= '0;
      end
`ifdef FIR_TAPLINE_FLUSH_EN
      r_flushCnt <= '0;
`endif
    end else begin
      r_state    <= w_nextState;
      r_winValid <= (w_accept && (w_countNext == FULL_COUNT)) || w_shiftZero || w_clearLine;
      if (w_accept) begin
        r_count      <= w_countNext;
        r_tapLine[0] <= DIN;
        for (int i = 1; i < TAPS; i++) begin
          r_tapLine[i] <= r_tapLine[i-1];
        end
      end
`ifdef FIR_TAPLINE_FLUSH_EN
      if (w_shiftZero) begin
        r_flushCnt   <= r_flushCnt + 1'b1;
        r_tapLine[0] <= '0;
        for (int i = 1; i < TAPS; i++) begin
          r_tapLine[i] <= r_tapLine[i-1];
        end
      end
      if (w_clearLine) begin
        r_flushCnt <= '0;
        r_count    <= '0;
        for (int i = 0; i < TAPS; i++) begin
          r_tapLine[i] <= '0;
        end
      end
`endif
    end
  end

`ifdef FIR_TAPLINE_FLUSH_EN
  assign DIN_READY = (r_state != ST_FLUSH);
`else
  assign DIN_READY = 1'b1;
`endif

  assign TP_W      = r_tapLine;
  assign WIN_VALID = r_winValid;

  fir_coef_bank #(
    .DATA_WIDTH (DATA_WIDTH),
    .TAPS       (TAPS)
  ) coefBank (
    .CLK          (CLK),
    .RST_n        (RST_n),
    .i_coefWe     (COEF_WE),
    .i_coefAddr   (COEF_ADDR),
    .i_coefData   (COEF_DATA),
    .i_coefCommit (COEF_COMMIT),
    .o_h          (H)
  );

endmodule : fir_tap_line

// File: tb/tb_fir_tap_line.sv
// tb_fir_tap_line: directed self-checking bench for fir_tap_line (TAPS=8).
// Flush scenarios are exercised only when FIR_TAPLINE_FLUSH_EN is defined.
module tb_fir_tap_line;

  localparam int DW   = 13;
  localparam int TAPS = 8;

  logic                 CLK;
  logic                 RST_n;
  logic signed [DW-1:0] DIN;
  logic                 DIN_VALID;
  logic                 DIN_READY;
  logic                 COEF_WE;
  logic [2:0]           COEF_ADDR;
  logic signed [DW-1:0] COEF_DATA;
  logic                 COEF_COMMIT;
  logic                 FLUSH;
  logic signed [DW-1:0] TP_W [0:TAPS-1];
  logic signed [DW-1:0] H [0:TAPS-1];
  logic                 WIN_VALID;

  int checkCount;
  int failCount;
  int expW [TAPS];

  fir_tap_line #(
    .DATA_WIDTH (DW),
    .TAPS       (TAPS)
  ) dut (
    .CLK         (CLK),
    .RST_n       (RST_n),
    .DIN         (DIN),
    .DIN_VALID   (DIN_VALID),
    .DIN_READY   (DIN_READY),
    .COEF_WE     (COEF_WE),
    .COEF_ADDR   (COEF_ADDR),
    .COEF_DATA   (COEF_DATA),
    .COEF_COMMIT (COEF_COMMIT),
    .FLUSH       (FLUSH),
    .TP_W        (TP_W),
    .H           (H),
    .WIN_VALID   (WIN_VALID)
  );

  // Free-running 10 ns clock.
  always #5 CLK = ~CLK;

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input int observed, input int expected);
    checkCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  task automatic checkWindow(input string tag, input int exp [TAPS]);
    for (int i = 0; i < TAPS; i++) begin
      checkOutput($sformatf("%s_tp%0d", tag, i), int'(TP_W[i]), exp[i]);
    end
  endtask

  // Drives one cycle of sample input and returns 1 ns after the edge.
  task automatic applyStimulus(input logic valid, input int sample);
    DIN_VALID = valid;
    DIN       = DW'(sample);
    @(posedge CLK);
    #1;
    DIN_VALID = 1'b0;
  endtask

  initial begin
    checkCount  = 0;
    failCount   = 0;
    CLK         = 1'b0;
    RST_n       = 1'b1;
    DIN         = '0;
    DIN_VALID   = 1'b0;
    COEF_WE     = 1'b0;
    COEF_ADDR   = '0;
    COEF_DATA   = '0;
    COEF_COMMIT = 1'b0;
    FLUSH       = 1'b0;

    // Reset values.
    #1 RST_n = 1'b0;
    #1;
    checkOutput("rst_winValid", int'(WIN_VALID), 0);
    checkOutput("rst_dinReady", int'(DIN_READY), 1);
    expW = '{0, 0, 0, 0, 0, 0, 0, 0};
    checkWindow("rst", expW);
    checkOutput("rst_h0", int'(H[0]), 0);
    checkOutput("rst_h7", int'(H[7]), 0);
    @(negedge CLK);
    @(negedge CLK);
    RST_n = 1'b1;

    // Fill with 1..8: strobe only after the 8th acceptance.
    for (int s = 1; s <= 8; s++) begin
      applyStimulus(1'b1, s);
      checkOutput($sformatf("fill_winValid_s%0d", s), int'(WIN_VALID), (s == 8) ? 1 : 0);
      checkOutput($sformatf("fill_tp0_s%0d", s), int'(TP_W[0]), s);
    end
    expW = '{8, 7, 6, 5, 4, 3, 2, 1};
    checkWindow("full", expW);

    // Idle cycles hold the window and give no strobe.
    for (int k = 0; k < 3; k++) begin
      applyStimulus(1'b0, 0);
      checkOutput($sformatf("idle_winValid_%0d", k), int'(WIN_VALID), 0);
      checkOutput($sformatf("idle_tp0_%0d", k), int'(TP_W[0]), 8);
    end
    applyStimulus(1'b1, 9);
    checkOutput("s9_winValid", int'(WIN_VALID), 1);
    expW = '{9, 8, 7, 6, 5, 4, 3, 2};
    checkWindow("s9", expW);
    applyStimulus(1'b0, 0);
    checkOutput("s9_pulseEnd", int'(WIN_VALID), 0);

    // Shadow writes alone must not reach H.
    for (int i = 0; i < TAPS; i++) begin
      COEF_WE   = 1'b1;
      COEF_ADDR = 3'(i);
      COEF_DATA = DW'(i + 1);
      @(posedge CLK);
      #1;
    end
    COEF_WE = 1'b0;
    checkOutput("shadow_h0", int'(H[0]), 0);
    checkOutput("shadow_h7", int'(H[7]), 0);

    COEF_COMMIT = 1'b1;
    @(posedge CLK);
    #1;
    COEF_COMMIT = 1'b0;
    for (int i = 0; i < TAPS; i++) begin
      checkOutput($sformatf("commit_h%0d", i), int'(H[i]), i + 1);
    end

    // Write plus commit in the same cycle: new value goes straight through.
    COEF_WE     = 1'b1;
    COEF_ADDR   = 3'd3;
    COEF_DATA   = 13'sd100;
    COEF_COMMIT = 1'b1;
    @(posedge CLK);
    #1;
    COEF_WE     = 1'b0;
    COEF_COMMIT = 1'b0;
    checkOutput("wrCommit_h3", int'(H[3]), 100);
    checkOutput("wrCommit_h2", int'(H[2]), 3);

    // Commit together with an acceptance: window appears with new H.
    COEF_WE   = 1'b1;
    COEF_ADDR = 3'd0;
    COEF_DATA = -13'sd5;
    @(posedge CLK);
    #1;
    COEF_WE     = 1'b0;
    COEF_COMMIT = 1'b1;
    applyStimulus(1'b1, 10);
    COEF_COMMIT = 1'b0;
    checkOutput("coCommit_winValid", int'(WIN_VALID), 1);
    checkOutput("coCommit_tp0", int'(TP_W[0]), 10);
    checkOutput("coCommit_h0", int'(H[0]), -5);
    checkOutput("coCommit_h3", int'(H[3]), 100);

    // Reset while a strobe is showing: everything clears at once.
    #2 RST_n = 1'b0;
    #1;
    checkOutput("midRst_winValid", int'(WIN_VALID), 0);
    checkOutput("midRst_tp0", int'(TP_W[0]), 0);
    checkOutput("midRst_tp1", int'(TP_W[1]), 0);
    checkOutput("midRst_h3", int'(H[3]), 0);
    @(negedge CLK);
    RST_n = 1'b1;

    // Line must refill completely before the next strobe.
    for (int s = 11; s <= 18; s++) begin
      applyStimulus(1'b1, s);
      checkOutput($sformatf("refill_winValid_s%0d", s), int'(WIN_VALID), (s == 18) ? 1 : 0);
    end
    expW = '{18, 17, 16, 15, 14, 13, 12, 11};
    checkWindow("refill", expW);

`ifdef FIR_TAPLINE_FLUSH_EN
    // Flush from RUN: 7 not-ready cycles, 7 strobes, then empty FILL.
    FLUSH = 1'b1;
    applyStimulus(1'b0, 0);
    FLUSH = 1'b0;
    checkOutput("flush_ready_0", int'(DIN_READY), 0);
    checkOutput("flush_winValid_0", int'(WIN_VALID), 0);
    for (int k = 1; k <= 7; k++) begin
      applyStimulus(1'b0, 0);
      checkOutput($sformatf("flush_winValid_%0d", k), int'(WIN_VALID), 1);
      checkOutput($sformatf("flush_tp0_%0d", k), int'(TP_W[0]), 0);
      checkOutput($sformatf("flush_ready_%0d", k), int'(DIN_READY), (k < 7) ? 0 : 1);
    end
    expW = '{0, 0, 0, 0, 0, 0, 0, 0};
    checkWindow("flushDone", expW);
    applyStimulus(1'b0, 0);
    checkOutput("flushDone_winValid", int'(WIN_VALID), 0);

    // Flush during FILL is ignored; 5 more samples after count 3 fill it.
    for (int s = 1; s <= 3; s++) begin
      applyStimulus(1'b1, s);
    end
    FLUSH = 1'b1;
    applyStimulus(1'b0, 0);
    FLUSH = 1'b0;
    checkOutput("fillFlush_ready", int'(DIN_READY), 1);
    for (int s = 4; s <= 8; s++) begin
      applyStimulus(1'b1, s);
      checkOutput($sformatf("fillFlush_winValid_s%0d", s), int'(WIN_VALID), (s == 8) ? 1 : 0);
    end
    expW = '{8, 7, 6, 5, 4, 3, 2, 1};
    checkWindow("fillFlush", expW);
`else
    // Without the flush feature the FLUSH pin has no effect.
    FLUSH = 1'b1;
    applyStimulus(1'b1, 19);
    FLUSH = 1'b0;
    checkOutput("noFlush_ready", int'(DIN_READY), 1);
    checkOutput("noFlush_winValid", int'(WIN_VALID), 1);
    checkOutput("noFlush_tp0", int'(TP_W[0]), 19);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
    $finish;
  end

endmodule : tb_fir_tap_line
